// File: rtl/hsv_blob_tracker.sv
// HSV window blob tracker: counts matching pixels per 90x60 frame, accumulates
// their coordinates and derives the integer centroid with a bit-serial divider.
module hsv_blob_tracker #(
   parameter int IMG_W   = 90,
   parameter int IMG_H   = 60,
   parameter int MIN_PIX = 16
) (
   input  logic        clk_llc,
   input  logic        reset,
   input  logic        pix_valid,
   input  logic [23:0] pix_hsv,
   input  logic        frame_start,
   input  logic [7:0]  h_min,
   input  logic [7:0]  h_max,
   input  logic [7:0]  s_min,
   input  logic [7:0]  v_min,
   output logic        res_valid,
   output logic [12:0] res_count,
   output logic [6:0]  res_x,
   output logic [5:0]  res_y,
   output logic        res_found,
   output logic        busy
);

   localparam logic [6:0]  X_LAST    = 7'(IMG_W - 1);
   localparam logic [5:0]  Y_LAST    = 6'(IMG_H - 1);
   localparam logic [12:0] FOUND_MIN = 13'(MIN_PIX);
   localparam logic [4:0]  DIV_LAST  = 5'd18;

   typedef enum logic [1:0] {IDLE, DIVX, DIVY, DONE} state_t;

   state_t      state, state_nxt;

   logic [7:0]  hue, sat, val;
   logic        hue_ok, pix_match, frame_end;
   logic [6:0]  x_p0, x_base;
   logic [5:0]  y_p0, y_base;
   logic [12:0] cnt_p0, cnt_base, cnt_nxt;
   logic [18:0] sum_x_p0, sum_x_base, sum_x_nxt;
   logic [18:0] sum_y_p0, sum_y_base, sum_y_nxt;

   logic        vld_p1;
   logic [12:0] snap_cnt_p1;
   logic [18:0] snap_sx_p1, snap_sy_p1;

   logic [12:0] rem_p2, step_rem;
   logic [18:0] quo_p2, step_quo;
   logic [6:0]  qx_p2;
   logic [4:0]  it_p2;
   logic        div_run, div_last, out_load;

   // One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
   function automatic logic [31:0] div_step(input logic [12:0] rem, input logic [18:0] quo,
                                            input logic [12:0] den);
      logic [13:0] shifted;
      logic [12:0] new_rem;
      logic        q_bit;
      shifted = {rem, quo[18]};
      q_bit   = (shifted >= {1'b0, den});
      new_rem = q_bit ? 13'(shifted - {1'b0, den}) : shifted[12:0];
      return {new_rem, quo[17:0], q_bit};
   endfunction

   assign hue = pix_hsv[23:16];
   assign sat = pix_hsv[15:8];
   assign val = pix_hsv[7:0];

   always_comb begin
      if (h_min <= h_max)
         hue_ok = (hue >= h_min) && (hue <= h_max);
      else
         hue_ok = (hue >= h_min) || (hue <= h_max);
      pix_match  = pix_valid && hue_ok && (sat >= s_min) && (val >= v_min);
      x_base     = frame_start ? 7'd0  : x_p0;
      y_base     = frame_start ? 6'd0  : y_p0;
      cnt_base   = frame_start ? 13'd0 : cnt_p0;
      sum_x_base = frame_start ? 19'd0 : sum_x_p0;
      sum_y_base = frame_start ? 19'd0 : sum_y_p0;
      frame_end  = pix_valid && (x_base == X_LAST) && (y_base == Y_LAST);
      cnt_nxt    = cnt_base + 13'(pix_match);
      sum_x_nxt  = sum_x_base + (pix_match ? 19'(x_base) : 19'd0);
      sum_y_nxt  = sum_y_base + (pix_match ? 19'(y_base) : 19'd0);
   end

   // Stage p0: raster position and live accumulators
   always_ff @(posedge clk_llc or posedge reset) begin
      if (reset) begin
         x_p0     <= '0;
         y_p0     <= '0;
         cnt_p0   <= '0;
         sum_x_p0 <= '0;
         sum_y_p0 <= '0;
      end else if (frame_end) begin
         x_p0     <= '0;
         y_p0     <= '0;
         cnt_p0   <= '0;
         sum_x_p0 <= '0;
         sum_y_p0 <= '0;
      end else if (pix_valid) begin
         cnt_p0   <= cnt_nxt;
         sum_x_p0 <= sum_x_nxt;
         sum_y_p0 <= sum_y_nxt;
         if (x_base == X_LAST) begin
            x_p0 <= '0;
            y_p0 <= y_base + 6'd1;
         end else begin
            x_p0 <= x_base + 7'd1;
            y_p0 <= y_base;
         end
      end else if (frame_start) begin
         x_p0     <= '0;
         y_p0     <= '0;
         cnt_p0   <= '0;
         sum_x_p0 <= '0;
         sum_y_p0 <= '0;
      end
   end

   // Stage p1: frame totals snapshot, including the pixel that ends the frame
   always_ff @(posedge clk_llc or posedge reset) begin
      if (reset) begin
         vld_p1      <= 1'b0;
         snap_cnt_p1 <= '0;
         snap_sx_p1  <= '0;
         snap_sy_p1  <= '0;
      end else begin
         vld_p1 <= frame_end;
         if (frame_end) begin
            snap_cnt_p1 <= cnt_nxt;
            snap_sx_p1  <= sum_x_nxt;
            snap_sy_p1  <= sum_y_nxt;
         end
      end
   end

   assign {step_rem, step_quo} = div_step(rem_p2, quo_p2, snap_cnt_p1);
   assign div_run  = (state == DIVX) || (state == DIVY);
   assign div_last = (it_p2 == DIV_LAST);
   assign out_load = (state == DIVY) && div_last && !frame_end;

   // Stage p2: divider datapath and result registers
   always_ff @(posedge clk_llc or posedge reset) begin
      if (reset) begin
         rem_p2    <= '0;
         quo_p2    <= '0;
         qx_p2     <= '0;
         it_p2     <= '0;
         res_count <= '0;
         res_x     <= '0;
         res_y     <= '0;
         res_found <= 1'b0;
      end else begin
         if (vld_p1) begin
            quo_p2 <= snap_sx_p1;
            rem_p2 <= '0;
            it_p2  <= '0;
         end else if (div_run) begin
            if (div_last) begin
               it_p2  <= '0;
               rem_p2 <= '0;
               if (state == DIVX) begin
                  qx_p2  <= step_quo[6:0];
                  quo_p2 <= snap_sy_p1;
               end else begin
                  quo_p2 <= step_quo;
               end
            end else begin
               rem_p2 <= step_rem;
               quo_p2 <= step_quo;
               it_p2  <= it_p2 + 5'd1;
            end
         end
         if (out_load) begin
            res_count <= snap_cnt_p1;
            res_found <= (snap_cnt_p1 >= FOUND_MIN);
            res_x     <= (snap_cnt_p1 == 13'd0) ? 7'd0 : qx_p2;
            res_y     <= (snap_cnt_p1 == 13'd0) ? 6'd0 : step_quo[5:0];
         end
      end
   end

   always_ff @(posedge clk_llc or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      res_valid = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (vld_p1)
               state_nxt = DIVX;
         end
         DIVX: if (div_last) state_nxt = DIVY;
         DIVY: if (div_last) state_nxt = DONE;
         DONE: begin
            res_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A new frame end abandons any division in flight; the fresh snapshot restarts it.
      if (frame_end)
         state_nxt = IDLE;
   end

endmodule
